mmio_io_bank: RTL and testbench

Parametrised memory-mapped I/O peripheral on the MIPS pipeline's data-memory bus. It succeeds the fixed single-word IN0/OUT0 locations at byte addresses 272/256 with NUM_CH input and NUM_CH output channels. Each channel is backed by a FIFO with valid/ready handshakes on the external side. A status word exposes per-channel occupancy and sticky error flags so software can poll before each access.

---
 rtl/mmio_io_bank.sv | 190 +++++++++++++++++++
 tb/tb_mmio_io_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_bank.sv
// mmio_io_bank -- memory-mapped I/O bank for the MIPS data-memory bus.
//
// NUM_CH output channels at OUT_BASE+4c and NUM_CH input channels at
// IN_BASE+4c. Each channel has its own FIFO with valid/ready on the external
// side. The status word at STATUS_ADDR reports per-channel occupancy and sticky
// error flags, so software can poll it before each access.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   Addr, WriteData       CPU byte address (word aligned) and store data
//   MemWrite, MemRead     CPU store / load strobes
//   ReadData, Hit         combinational load data and address-hit flag
//   out_data/out_valid/out_ready   output FIFO heads toward the external sink
//   in_data/in_valid/in_ready      external source into the input FIFOs
//
// Build option: define MMIO_IO_ERR_FLAGS_EN to add the sticky err_ovf/err_udf
// flags (status bits [31:16], cleared by writing 1). When it is undefined,
// those status bits read 0 and status stores are ignored.

module mmio_io_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PW-1:0]           rptr_q, wptr_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    push_ok, pop_ok;

    // Full and empty come from the registered count only. A push into a full
    // FIFO is refused even when a pop happens in the same cycle, and the same
    // holds for a pop from an empty FIFO.
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop_ok) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end
endmodule

module mmio_io_bank #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 16,
    parameter int                NUM_CH      = 4,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] OUT_BASE    = 16'd256,
    parameter logic [ADDR_W-1:0] IN_BASE     = 16'd272,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 16'd288
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        Addr,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    output logic [DATA_W-1:0]        ReadData,
    output logic                     Hit,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready
);
    logic [NUM_CH-1:0][DATA_W-1:0] in_data_a, out_head, in_head;
    logic [NUM_CH-1:0] out_hit, in_hit, out_full, out_empty, in_full, in_empty;
    logic [NUM_CH-1:0] err_ovf, err_udf;
    logic              st_hit;
    logic [31:0]       status;
    logic [DATA_W-1:0] rdata;
    logic              unused_addr_lsb;

    // Word accesses only: the byte offset plays no part in decode.
    assign unused_addr_lsb = ^Addr[1:0];
    assign in_data_a = in_data;
    assign st_hit    = (Addr[ADDR_W-1:2] == STATUS_ADDR[ADDR_W-1:2]);
    assign Hit       = (|out_hit) || (|in_hit) || st_hit;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [ADDR_W-1:0] OA = OUT_BASE + ADDR_W'(4 * c);
        localparam logic [ADDR_W-1:0] IA = IN_BASE + ADDR_W'(4 * c);

        assign out_hit[c] = (Addr[ADDR_W-1:2] == OA[ADDR_W-1:2]);
        assign in_hit[c]  = (Addr[ADDR_W-1:2] == IA[ADDR_W-1:2]);

        mmio_io_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_out (
            .clk_i   (clk),
            .rst_ni  (rst),
            .push_i  (MemWrite && out_hit[c]),
            .pop_i   (out_ready[c]),
            .wdata_i (WriteData),
            .head_o  (out_head[c]),
            .full_o  (out_full[c]),
            .empty_o (out_empty[c])
        );

        mmio_io_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_in (
            .clk_i   (clk),
            .rst_ni  (rst),
            .push_i  (in_valid[c]),
            .pop_i   (MemRead && in_hit[c]),
            .wdata_i (in_data_a[c]),
            .head_o  (in_head[c]),
            .full_o  (in_full[c]),
            .empty_o (in_empty[c])
        );
    end

    assign out_data  = out_head;
    assign out_valid = ~out_empty;
    assign in_ready  = ~in_full;

`ifdef MMIO_IO_ERR_FLAGS_EN
    logic [NUM_CH-1:0] err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
    logic [NUM_CH-1:0] ovf_set, udf_set, ovf_clr, udf_clr;

    assign ovf_set = {NUM_CH{MemWrite}} & out_hit & out_full;
    assign udf_set = {NUM_CH{MemRead}} & in_hit & in_empty;
    assign ovf_clr = (MemWrite && st_hit) ? WriteData[16 +: NUM_CH] : '0;
    assign udf_clr = (MemWrite && st_hit) ? WriteData[24 +: NUM_CH] : '0;
    // The set term is ORed in after the clear, so a set wins over a clear
    // of the same bit in the same cycle.
    assign err_ovf_d = (err_ovf_q & ~ovf_clr) | ovf_set;
    assign err_udf_d = (err_udf_q & ~udf_clr) | udf_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ovf_q <= '0;
            err_udf_q <= '0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`else
    assign err_ovf = '0;
    assign err_udf = '0;
`endif

    always_comb begin
        status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            status[c]      = !in_empty[c];
            status[8 + c]  = !out_full[c];
            status[16 + c] = err_ovf[c];
            status[24 + c] = err_udf[c];
        end
    end

    // Load data for the MEM stage. Output-channel loads and loads from an
    // empty input FIFO fall through to 0.
    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_hit[c] && !in_empty[c]) rdata = in_head[c];
        end
        if (st_hit) rdata = DATA_W'(status);
        ReadData = MemRead ? rdata : '0;
    end
endmodule

// File: tb/tb_mmio_io_bank.sv
module tb_mmio_io_bank;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
`ifdef MMIO_IO_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  Addr = '0;
    logic [31:0]  WriteData = '0;
    logic         MemWrite = 1'b0, MemRead = 1'b0;
    logic [31:0]  ReadData;
    logic         Hit;
    logic [127:0] out_data;
    logic [3:0]   out_valid, in_ready;
    logic [3:0]   out_ready = '0, in_valid = '0;
    logic [127:0] in_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per FIFO plus the sticky flag bits.
    logic [31:0] outq[NCH][$];
    logic [31:0] inq[NCH][$];
    logic [3:0]  m_ovf = '0, m_udf = '0;

    always #5 clk = ~clk;

    mmio_io_bank dut (
        .clk(clk), .rst(rst), .Addr(Addr), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    function automatic logic [31:0] exp_status();
        logic [31:0] s = '0;
        for (int c = 0; c < NCH; c++) begin
            s[c]      = inq[c].size() > 0;
            s[8 + c]  = outq[c].size() < DEPTH;
            s[16 + c] = m_ovf[c];
            s[24 + c] = m_udf[c];
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_rdata();
        int w = int'(Addr[15:2]);
        if (!MemRead) return '0;
        if (w == 72) return exp_status();
        if (w >= 68 && w < 72) return (inq[w - 68].size() > 0) ? inq[w - 68][0] : 32'h0;
        return '0;
    endfunction

    function automatic logic exp_hit();
        int w = int'(Addr[15:2]);
        return (w >= 64 && w <= 72);
    endfunction

    function automatic logic [3:0] exp_in_ready();
        logic [3:0] r;
        for (int c = 0; c < NCH; c++) r[c] = inq[c].size() < DEPTH;
        return r;
    endfunction

    function automatic logic [3:0] exp_out_valid();
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = outq[c].size() > 0;
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            outq[c].delete();
            inq[c].delete();
        end
        m_ovf = '0;
        m_udf = '0;
    endtask

    // Applies the current inputs to the model from the pre-edge occupancies,
    // then advances the DUT by one clock.
    task automatic tick();
        int w = int'(Addr[15:2]);
        int osz[NCH];
        int isz[NCH];
        logic [31:0] junk;
        logic [3:0] oset = '0, uset = '0;
        for (int c = 0; c < NCH; c++) begin
            osz[c] = outq[c].size();
            isz[c] = inq[c].size();
        end
        for (int c = 0; c < NCH; c++) begin
            if (MemWrite && w == 64 + c) begin
                if (osz[c] < DEPTH) outq[c].push_back(WriteData);
                else oset[c] = 1'b1;
            end
            if (out_ready[c] && osz[c] > 0) junk = outq[c].pop_front();
            if (in_valid[c] && isz[c] < DEPTH) inq[c].push_back(in_data[c*32 +: 32]);
            if (MemRead && w == 68 + c) begin
                if (isz[c] > 0) junk = inq[c].pop_front();
                else uset[c] = 1'b1;
            end
        end
        if (FLAGS) begin
            if (MemWrite && w == 72) begin
                m_ovf = m_ovf & ~WriteData[19:16];
                m_udf = m_udf & ~WriteData[27:24];
            end
            m_ovf = m_ovf | oset;
            m_udf = m_udf | uset;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        MemWrite = 0; MemRead = 0; in_valid = '0; out_ready = '0;
    endtask

    task automatic test_reset();
        rst = 0; in_valid = 4'hF; MemRead = 1; Addr = 16'd288;
        @(negedge clk); #1;
        n_cmp++; if (in_ready !== 4'hF) begin n_err++; $display("FAIL reset_in_ready: got %h want f", in_ready); end
        n_cmp++; if (out_valid !== 4'h0) begin n_err++; $display("FAIL reset_out_valid: got %h want 0", out_valid); end
        n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (ReadData !== 32'h0000_0F00) begin n_err++; $display("FAIL reset_status: got %h want 00000f00", ReadData); end
        n_cmp++; if (Hit !== 1'b1) begin n_err++; $display("FAIL reset_hit: got %b want 1", Hit); end
        idle();
        model_clear();
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_output_path();
        MemWrite = 1; Addr = 16'd260; WriteData = 32'hABCD7FAF;
        tick();
        MemWrite = 0; #1;
        n_cmp++; if (out_valid !== 4'b0010) begin n_err++; $display("FAIL out_valid_after_store: got %b want 0010", out_valid); end
        n_cmp++; if (out_data[63:32] !== 32'hABCD7FAF) begin n_err++; $display("FAIL out_data_ch1: got %h want abcd7faf", out_data[63:32]); end
        out_ready = 4'b0010;
        tick();
        out_ready = '0; #1;
        n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL out_valid_after_drain: got %b want 0", out_valid[1]); end
    endtask

    task automatic test_output_overflow();
        logic [31:0] want;
        for (int i = 1; i <= 5; i++) begin
            MemWrite = 1; Addr = 16'd256; WriteData = 32'(i);
            tick();
        end
        MemWrite = 0; MemRead = 1; Addr = 16'd288; #1;
        want = 32'h0000_0E00 | (FLAGS ? 32'h0001_0000 : 32'h0);
        n_cmp++; if (ReadData !== want) begin n_err++; $display("FAIL ovf_status: got %h want %h", ReadData, want); end
        n_cmp++; if (ReadData[16] !== FLAGS) begin n_err++; $display("FAIL ovf_bit16: got %b want %b", ReadData[16], FLAGS); end
        MemRead = 0; out_ready = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_cmp++; if (out_data[31:0] !== 32'(i) || out_valid[0] !== 1'b1) begin
                n_err++; $display("FAIL ovf_drain_%0d: got %h/%b want %h/1", i, out_data[31:0], out_valid[0], i);
            end
            tick();
        end
        out_ready = '0; #1;
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL ovf_drained_empty: got %b want 0", out_valid[0]); end
        MemWrite = 1; Addr = 16'd288; WriteData = 32'h0001_0000;
        tick();
        MemWrite = 0; MemRead = 1; #1;
        n_cmp++; if (ReadData !== 32'h0000_0F00) begin n_err++; $display("FAIL ovf_w1c: got %h want 00000f00", ReadData); end
        MemRead = 0;
    endtask

    task automatic test_input_path();
        logic [31:0] want[3] = '{32'h12, 32'h34, 32'h0};
        in_valid = 4'b1000; in_data[127:96] = 32'h12;
        tick();
        in_data[127:96] = 32'h34;
        tick();
        in_valid = '0; MemRead = 1; Addr = 16'd284;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ReadData !== want[i]) begin n_err++; $display("FAIL in_load_%0d: got %h want %h", i, ReadData, want[i]); end
            tick();
        end
        Addr = 16'd288; #1;
        n_cmp++; if (ReadData[27] !== FLAGS || ReadData[3] !== 1'b0) begin
            n_err++; $display("FAIL udf_status: got %h want bit27=%b bit3=0", ReadData, FLAGS);
        end
        MemRead = 0;
    endtask

    task automatic test_simultaneous();
        in_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            in_data[31:0] = 32'hA0 + 32'(i);
            tick();
        end
        in_data[31:0] = 32'hA4; MemRead = 1; Addr = 16'd272; #1;
        n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready[0]); end
        n_cmp++; if (ReadData !== 32'hA0) begin n_err++; $display("FAIL full_pop_data: got %h want a0", ReadData); end
        tick();
        in_valid = '0; #1;
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL full_count3_ready: got %b want 1", in_ready[0]); end
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_cmp++; if (ReadData !== ((i < 4) ? 32'hA0 + 32'(i) : 32'h0)) begin
                n_err++; $display("FAIL full_drain_%0d: got %h want %h", i, ReadData, (i < 4) ? 32'hA0 + 32'(i) : 32'h0);
            end
            tick();
        end
        in_valid = 4'b0001; in_data[31:0] = 32'h55; #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL empty_pushpop_data: got %h want 0", ReadData); end
        tick();
        in_valid = '0; #1;
        n_cmp++; if (ReadData !== 32'h55) begin n_err++; $display("FAIL empty_pushpop_landed: got %h want 55", ReadData); end
        tick();
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL empty_pushpop_count1: got %h want 0", ReadData); end
        tick();
        MemRead = 0;
    endtask

    task automatic test_async_reset();
        MemWrite = 1; Addr = 16'd256; WriteData = 32'h11;
        tick();
        WriteData = 32'h22;
        tick();
        MemWrite = 0; in_valid = 4'b0100; in_data[95:64] = 32'h99;
        tick();
        tick();
        in_valid = '0; MemRead = 1; Addr = 16'd288;
        #2 rst = 0;
        #1;
        n_cmp++; if (out_valid !== 4'h0) begin n_err++; $display("FAIL arst_out_valid: got %h want 0", out_valid); end
        n_cmp++; if (in_ready !== 4'hF) begin n_err++; $display("FAIL arst_in_ready: got %h want f", in_ready); end
        n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL arst_out_data: got %h want 0", out_data); end
        n_cmp++; if (ReadData !== 32'h0000_0F00) begin n_err++; $display("FAIL arst_status: got %h want 00000f00", ReadData); end
        model_clear();
        @(negedge clk);
        rst = 1; MemRead = 0;
        MemWrite = 1; Addr = 16'd256; WriteData = 32'h77;
        tick();
        MemWrite = 0; #1;
        n_cmp++; if (out_data[31:0] !== 32'h77 || out_valid !== 4'b0001) begin
            n_err++; $display("FAIL arst_first_store: got %h/%b want 77/0001", out_data[31:0], out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 400; n++) begin
            Addr      = 16'(248 + $urandom_range(0, 47));
            MemWrite  = ($urandom_range(0, 9) < 4);
            MemRead   = ($urandom_range(0, 9) < 5);
            WriteData = $urandom;
            in_valid  = 4'($urandom);
            out_ready = 4'($urandom & $urandom);
            for (int c = 0; c < NCH; c++) in_data[c*32 +: 32] = $urandom;
            #1;
            e = exp_rdata();
            n_cmp++; if (ReadData !== e) begin n_err++; $display("FAIL rnd_rdata[%0d]: addr %0d got %h want %h", n, Addr, ReadData, e); end
            n_cmp++; if (Hit !== exp_hit()) begin n_err++; $display("FAIL rnd_hit[%0d]: addr %0d got %b want %b", n, Addr, Hit, exp_hit()); end
            n_cmp++; if (in_ready !== exp_in_ready()) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %h want %h", n, in_ready, exp_in_ready()); end
            n_cmp++; if (out_valid !== exp_out_valid()) begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %h want %h", n, out_valid, exp_out_valid()); end
            for (int c = 0; c < NCH; c++) begin
                if (outq[c].size() > 0) begin
                    n_cmp++; if (out_data[c*32 +: 32] !== outq[c][0]) begin
                        n_err++; $display("FAIL rnd_out_data[%0d] ch%0d: got %h want %h", n, c, out_data[c*32 +: 32], outq[c][0]);
                    end
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_output_path();
        test_output_overflow();
        test_input_path();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
